// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle controller and its datapath: instruction
// fields and flags in, load enables and mux selects out.
interface mc_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_wr;
    logic       ir_wr;
    logic [1:0] npc_sel;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [1:0] ext_op;
    logic       mem_wr;
    logic [1:0] mem_to_reg;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_wr, ir_wr, npc_sel, reg_wr, reg_dst, alu_src, alu_op,
               ext_op, mem_wr, mem_to_reg, illegal, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_wr, ir_wr, npc_sel, reg_wr, reg_dst, alu_src, alu_op,
               ext_op, mem_wr, mem_to_reg, illegal, state
    );
endinterface

// File: rtl/mc_ctrl.sv
// Moore-style multi-cycle controller for a small MIPS subset (lw/sw/addu/subu/
// ori/lui/beq/j/jal). Outputs decode from the state and the captured instruction.
module mc_ctrl (
    input  logic        clk,
    input  logic        reset,
    mc_ctrl_if.master   bus
);

    typedef enum logic [3:0] {
        S_FETCH = 4'd0,
        S_DCD   = 4'd1,
        S_MA    = 4'd2,
        S_MR    = 4'd3,
        S_MW    = 4'd4,
        S_WBM   = 4'd5,
        S_EXE   = 4'd6,
        S_WBA   = 4'd7,
        S_BR    = 4'd8,
        S_JMP   = 4'd9
    } state_e;

    typedef enum logic [3:0] {
        C_LW, C_SW, C_ADDU, C_SUBU, C_ORI, C_LUI, C_BEQ, C_J, C_JAL, C_ILL
    } iclass_e;

    state_e     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;
    logic [5:0] funct_q, funct_d;
    iclass_e    cur_class_s;
    iclass_e    dcd_class_s;

    logic       pc_wr_s, ir_wr_s, reg_wr_s, mem_wr_s, illegal_s;
    logic [1:0] npc_sel_s, reg_dst_s, alu_op_s, ext_op_s, mem_to_reg_s;
    logic       alu_src_s;

    function automatic iclass_e decode(input logic [5:0] op, input logic [5:0] fn);
        iclass_e c;
        case (op)
            6'b100011: c = C_LW;
            6'b101011: c = C_SW;
            6'b000000: begin
                if (fn == 6'b100001) begin
                    c = C_ADDU;
                end else if (fn == 6'b100011) begin
                    c = C_SUBU;
                end else begin
                    c = C_ILL;
                end
            end
            6'b001101: c = C_ORI;
            6'b001111: c = C_LUI;
            6'b000100: c = C_BEQ;
            6'b000010: c = C_J;
            6'b000011: c = C_JAL;
            default:   c = C_ILL;
        endcase
        return c;
    endfunction

    assign cur_class_s = decode(opcode_q, funct_q);
    // DCD is the cycle the instruction register has just been loaded; its value is what gets captured.
    assign dcd_class_s = decode(bus.opcode, bus.funct);

    // State register and captured instruction fields
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            opcode_q <= 6'd0;
            funct_q  <= 6'd0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            funct_q  <= funct_d;
        end
    end

    // Next-state and instruction capture
    always_comb begin
        state_d  = S_FETCH;
        opcode_d = opcode_q;
        funct_d  = funct_q;
        case (state_q)
            S_FETCH: state_d = S_DCD;
            S_DCD: begin
                opcode_d = bus.opcode;
                funct_d  = bus.funct;
                case (dcd_class_s)
                    C_LW, C_SW:                  state_d = S_MA;
                    C_ADDU, C_SUBU, C_ORI, C_LUI: state_d = S_EXE;
                    C_BEQ:                       state_d = S_BR;
                    C_J, C_JAL:                  state_d = S_JMP;
                    default:                     state_d = S_FETCH;
                endcase
            end
            S_MA: begin
                if (cur_class_s == C_SW) begin
                    state_d = S_MW;
                end else begin
                    state_d = S_MR;
                end
            end
            S_MR: begin
                if (bus.mem_ready) begin
                    state_d = S_WBM;
                end else begin
                    state_d = S_MR;
                end
            end
            S_MW: begin
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MW;
                end
            end
            S_EXE:   state_d = S_WBA;
            default: state_d = S_FETCH;
        endcase
    end

    // Per-state output decode
    always_comb begin
        pc_wr_s      = 1'b0;
        ir_wr_s      = 1'b0;
        reg_wr_s     = 1'b0;
        mem_wr_s     = 1'b0;
        illegal_s    = 1'b0;
        npc_sel_s    = 2'b00;
        reg_dst_s    = 2'b00;
        alu_src_s    = 1'b0;
        alu_op_s     = 2'b00;
        ext_op_s     = 2'b00;
        mem_to_reg_s = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_wr_s = 1'b1;
                pc_wr_s = 1'b1;
            end
            S_DCD: illegal_s = (dcd_class_s == C_ILL);
            S_MA: begin
                alu_src_s = 1'b1;
                ext_op_s  = 2'b01;
            end
            S_MW: mem_wr_s = 1'b1;
            S_WBM: begin
                reg_wr_s     = 1'b1;
                mem_to_reg_s = 2'b01;
            end
            S_EXE: begin
                case (cur_class_s)
                    C_SUBU: alu_op_s = 2'b01;
                    C_ORI: begin
                        alu_src_s = 1'b1;
                        alu_op_s  = 2'b10;
                    end
                    C_LUI: begin
                        alu_src_s = 1'b1;
                        ext_op_s  = 2'b10;
                        alu_op_s  = 2'b11;
                    end
                    default: alu_op_s = 2'b00;
                endcase
            end
            S_WBA: begin
                reg_wr_s = 1'b1;
                if (opcode_q == 6'b000000) begin
                    reg_dst_s = 2'b01;
                end else begin
                    reg_dst_s = 2'b00;
                end
            end
            S_BR: begin
                alu_op_s  = 2'b01;
                npc_sel_s = 2'b01;
                pc_wr_s   = bus.zero;
            end
            S_JMP: begin
                pc_wr_s = 1'b1;
                if (cur_class_s == C_JAL) begin
                    npc_sel_s    = 2'b11;
                    reg_wr_s     = 1'b1;
                    reg_dst_s    = 2'b10;
                    mem_to_reg_s = 2'b10;
                end else begin
                    npc_sel_s = 2'b10;
                end
            end
            default: pc_wr_s = 1'b0;
        endcase
    end

    // Reset gates every strobe combinationally so nothing fires while it is held.
    assign bus.pc_wr      = pc_wr_s   & ~reset;
    assign bus.ir_wr      = ir_wr_s   & ~reset;
    assign bus.reg_wr     = reg_wr_s  & ~reset;
    assign bus.mem_wr     = mem_wr_s  & ~reset;
    assign bus.illegal    = illegal_s & ~reset;
    assign bus.npc_sel    = npc_sel_s;
    assign bus.reg_dst    = reg_dst_s;
    assign bus.alu_src    = alu_src_s;
    assign bus.alu_op     = alu_op_s;
    assign bus.ext_op     = ext_op_s;
    assign bus.mem_to_reg = mem_to_reg_s;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: builds the expected per-cycle output trace of each
// instruction from the opcode table and compares it cycle by cycle.
module tb_mc_ctrl;

    logic clk;
    logic reset;
    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        mr;
        logic [19:0] exp;
    } cyc_t;

    cyc_t q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                           OP_ORI = 6'b001101, OP_LUI = 6'b001111, OP_BEQ = 6'b000100,
                           OP_J = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [5:0] FN_ADDU = 6'b100001, FN_SUBU = 6'b100011;

    // {state, pc_wr, ir_wr, npc_sel, reg_wr, reg_dst, alu_src, alu_op, ext_op, mem_wr, mem_to_reg, illegal}
    function automatic logic [19:0] mk(input logic [3:0] st, input logic pc, input logic ir,
                                       input logic [1:0] npc, input logic rw, input logic [1:0] rd,
                                       input logic as, input logic [1:0] ao, input logic [1:0] eo,
                                       input logic mw, input logic [1:0] m2r, input logic il);
        return {st, pc, ir, npc, rw, rd, as, ao, eo, mw, m2r, il};
    endfunction

    function automatic logic [19:0] observed();
        return {bus.state, bus.pc_wr, bus.ir_wr, bus.npc_sel, bus.reg_wr, bus.reg_dst,
                bus.alu_src, bus.alu_op, bus.ext_op, bus.mem_wr, bus.mem_to_reg, bus.illegal};
    endfunction

    task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // mrv/zsel < 0 means drive a random value that the controller must ignore.
    task automatic add(input logic [19:0] e, input int mrv, input int zsel, input bit is_dcd,
                       input logic [5:0] op, input logic [5:0] fn, input bit br);
        cyc_t c;
        c.op  = is_dcd ? op : 6'($urandom);
        c.fn  = is_dcd ? fn : 6'($urandom);
        c.z   = (zsel < 0) ? 1'($urandom) : 1'(zsel);
        c.mr  = (mrv < 0) ? 1'($urandom) : 1'(mrv);
        if (br) e[15] = c.z;
        c.exp = e;
        q.push_back(c);
    endtask

    // Expected trace of one instruction, starting with its FETCH cycle.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int waits, input int zsel);
        bit lw, sw, addu, subu, ori, lui, beq, j, jal, ill;
        lw   = (op == OP_LW);
        sw   = (op == OP_SW);
        addu = (op == OP_R) && (fn == FN_ADDU);
        subu = (op == OP_R) && (fn == FN_SUBU);
        ori  = (op == OP_ORI);
        lui  = (op == OP_LUI);
        beq  = (op == OP_BEQ);
        j    = (op == OP_J);
        jal  = (op == OP_JAL);
        ill  = !(lw || sw || addu || subu || ori || lui || beq || j || jal);
        add(mk(4'd0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0), -1, zsel, 1'b0, op, fn, 1'b0);
        add(mk(4'd1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'(ill)), -1, zsel, 1'b1, op, fn, 1'b0);
        if (lw || sw)
            add(mk(4'd2, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0), -1, zsel, 1'b0, op, fn, 1'b0);
        if (lw) begin
            for (int i = 0; i < waits; i++)
                add(mk(4'd3, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0), 0, zsel, 1'b0, op, fn, 1'b0);
            add(mk(4'd3, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0), 1, zsel, 1'b0, op, fn, 1'b0);
            add(mk(4'd5, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0), -1, zsel, 1'b0, op, fn, 1'b0);
        end
        if (sw) begin
            for (int i = 0; i <= waits; i++)
                add(mk(4'd4, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0),
                    (i == waits) ? 1 : 0, zsel, 1'b0, op, fn, 1'b0);
        end
        if (addu || subu || ori || lui) begin
            add(mk(4'd6, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'(ori || lui),
                   subu ? 2'b01 : ori ? 2'b10 : lui ? 2'b11 : 2'b00,
                   lui ? 2'b10 : 2'b00, 1'b0, 2'b00, 1'b0), -1, zsel, 1'b0, op, fn, 1'b0);
            add(mk(4'd7, 1'b0, 1'b0, 2'b00, 1'b1, (addu || subu) ? 2'b01 : 2'b00, 1'b0, 2'b00, 2'b00,
                   1'b0, 2'b00, 1'b0), -1, zsel, 1'b0, op, fn, 1'b0);
        end
        if (beq)
            add(mk(4'd8, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0), -1, zsel, 1'b0, op, fn, 1'b1);
        if (j)
            add(mk(4'd9, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0), -1, zsel, 1'b0, op, fn, 1'b0);
        if (jal)
            add(mk(4'd9, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0), -1, zsel, 1'b0, op, fn, 1'b0);
    endtask

    // Plays n queued cycles (all if n < 0): drive after the edge, check at the falling edge.
    task automatic run(input string tag, input int n);
        int k = 0;
        while (q.size() > 0 && (n < 0 || k < n)) begin
            cyc_t c;
            c = q.pop_front();
            bus.opcode    = c.op;
            bus.funct     = c.fn;
            bus.zero      = c.z;
            bus.mem_ready = c.mr;
            @(negedge clk);
            check($sformatf("%s st%0d", tag, c.exp[19:16]), observed(), c.exp);
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    logic [19:0] idle_v;
    logic [5:0]  ops [0:8];

    initial begin
        idle_v = mk(4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
        ops = '{OP_LW, OP_SW, OP_R, OP_R, OP_ORI, OP_LUI, OP_BEQ, OP_J, OP_JAL};
        reset         = 1'b1;
        bus.opcode    = OP_LW;
        bus.funct     = 6'd0;
        bus.zero      = 1'b1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("reset_hold", observed(), idle_v);
        @(negedge clk);
        check("reset_hold2", observed(), idle_v);
        @(posedge clk);
        #1;
        reset = 1'b0;

        build(OP_LW, 6'd0, 0, -1);       run("lw", -1);
        build(OP_SW, 6'd0, 3, -1);       run("sw_wait3", -1);
        build(OP_BEQ, 6'd0, 0, 1);       run("beq_z1", -1);
        build(OP_BEQ, 6'd0, 0, 0);       run("beq_z0", -1);
        build(OP_JAL, 6'd0, 0, -1);      run("jal", -1);
        build(OP_J, 6'd0, 0, -1);        run("j", -1);
        build(6'b111111, 6'd0, 0, -1);   run("illegal", -1);
        build(OP_R, FN_ADDU, 0, -1);     run("addu", -1);
        build(OP_R, FN_SUBU, 0, -1);     run("subu", -1);
        build(OP_ORI, 6'd0, 0, -1);      run("ori", -1);
        build(OP_LUI, 6'd0, 0, -1);      run("lui", -1);
        build(OP_R, 6'b000000, 0, -1);   run("r_bad_funct", -1);
        build(OP_LW, 6'd0, 2, -1);       run("lw_wait2", -1);

        // Reset lands between edges while a store is stalled in MW.
        build(OP_SW, 6'd0, 5, -1);
        run("sw_pre_reset", 5);
        q.delete();
        bus.mem_ready = 1'b0;
        #1;
        check("mw_before_reset", observed(),
              mk(4'd4, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0));
        reset = 1'b1;
        #1;
        check("mw_async_reset", observed(), idle_v);
        @(posedge clk);
        #1;
        check("reset_over_edge", observed(), idle_v);
        reset = 1'b0;
        build(OP_ORI, 6'd0, 0, -1);      run("after_reset", -1);

        for (int i = 0; i < 60; i++) begin
            int sel;
            logic [5:0] op, fn;
            sel = $urandom_range(0, 10);
            if (sel <= 8) begin
                op = ops[sel];
                fn = (sel == 2) ? FN_ADDU : (sel == 3) ? FN_SUBU : 6'($urandom);
            end else begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end
            build(op, fn, $urandom_range(0, 3), -1);
            run($sformatf("rand%0d", i), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 opcode  input  6  instr[31:26] from instruction register.
REQ-004 funct  input  6  instr[5:0] from instruction register.
REQ-005 zero  input  1  ALU equality flag for beq.
REQ-006 mem_ready  input  1  data memory done; sampled in MR and MW states only.
REQ-007 pc_wr  output  1  PC load enable.
REQ-008 ir_wr  output  1  instruction register load enable.
REQ-009 npc_sel  output  2  next-PC select: 00 pc+4, 01 branch target, 10 j target, 11 jal target.
REQ-010 reg_wr  output  1  register file write enable.
REQ-011 reg_dst  output  2  write-register select: 00 rt, 01 rd, 10 r31.
REQ-012 alu_src  output  1  0 register rt, 1 extended immediate.
REQ-013 alu_op  output  2  00 add, 01 sub, 10 or, 11 lui-pass.
REQ-014 ext_op  output  2  00 zero-extend, 01 sign-extend, 10 load-upper.
REQ-015 mem_wr  output  1  data memory write strobe.
REQ-016 mem_to_reg  output  2  write-data select: 00 ALU, 01 memory, 10 PC link.
REQ-017 illegal  output  1  one-cycle pulse on unsupported instruction.
REQ-018 state  output  4  current state code, debug visibility.

Function
REQ-019 Moore FSM; all outputs SHALL decode from the state register and the opcode/funct captured in DCD, never from live opcode/funct.
REQ-020 State codes: FETCH=0, DCD=1, MA=2, MR=3, MW=4, WBM=5, EXE=6, WBA=7, BR=8, JMP=9; codes 10-15 SHALL go to FETCH next cycle with all strobes low.
REQ-021 FETCH: ir_wr=1, pc_wr=1, npc_sel=00; next DCD.
REQ-022 DCD: latch opcode/funct; all strobes 0. Next state: lw(100011)/sw(101011) -> MA; R-type(000000) with funct addu(100001)/subu(100011) -> EXE; ori(001101)/lui(001111) -> EXE; beq(000100) -> BR; j(000010)/jal(000011) -> JMP; any other -> FETCH, with illegal=1 in that DCD cycle.
REQ-023 MA: alu_src=1, ext_op=01, alu_op=00; next MR for lw, MW for sw.
REQ-024 MR: hold while mem_ready=0; on mem_ready=1 -> WBM.
REQ-025 MW: mem_wr=1 every cycle in state; hold while mem_ready=0; on mem_ready=1 -> FETCH.
REQ-026 WBM: reg_wr=1, reg_dst=00, mem_to_reg=01; next FETCH.
REQ-027 EXE: addu alu_src=0/alu_op=00; subu alu_src=0/alu_op=01; ori alu_src=1/ext_op=00/alu_op=10; lui alu_src=1/ext_op=10/alu_op=11; next WBA.
REQ-028 WBA: reg_wr=1, mem_to_reg=00, reg_dst=01 for R-type else 00; next FETCH.
REQ-029 BR: alu_src=0, alu_op=01, npc_sel=01, pc_wr=zero (same cycle); next FETCH regardless of zero.
REQ-030 JMP: pc_wr=1; j: npc_sel=10, reg_wr=0; jal: npc_sel=11, reg_wr=1, reg_dst=10, mem_to_reg=10; next FETCH.
REQ-031 Latency (no memory wait): lw 5, sw 4, R/ori/lui 4, beq 3, j/jal 3 cycles; each wait cycle adds 1 to lw/sw.
REQ-032 Outside named assertions, every strobe (pc_wr, ir_wr, reg_wr, mem_wr, illegal) SHALL be 0; mux selects default 00/0.
REQ-033 At most one of pc_wr-in-non-FETCH, reg_wr, mem_wr SHALL be asserted except jal JMP (pc_wr+reg_wr).

Reset
REQ-034 reset=1 SHALL force state=FETCH immediately, asynchronously, regardless of clk, and clear latched opcode/funct to 0.
REQ-035 During reset all strobes SHALL be 0 (pc_wr and ir_wr gated by reset); first FETCH cycle occurs on the first rising clk edge after reset deasserts.
REQ-036 Reset mid-instruction (including MW with mem_wr=1) SHALL drop all strobes in the same delta; no partial write completes afterward.

Verification
REQ-037 lw, mem_ready tied 1 -> states 0,1,2,3,5,0; reg_wr=1 with mem_to_reg=01 only in WBM; 5 cycles.
REQ-038 sw, mem_ready low 3 cycles in MW -> mem_wr=1 for 4 cycles, state 4 held, then FETCH; no reg_wr.
REQ-039 beq with zero=1 then zero=0 -> BR pc_wr=1/npc_sel=01, then pc_wr=0; both return to FETCH after 3 cycles.
REQ-040 jal -> JMP pc_wr=1, npc_sel=11, reg_wr=1, reg_dst=10, mem_to_reg=10; j -> reg_wr=0, npc_sel=10.
REQ-041 opcode 111111 -> illegal=1 for one cycle in DCD, then FETCH; no reg_wr/mem_wr.
REQ-042 reset asserted between clk edges during MW -> state=0, mem_wr=0 before next edge; release -> FETCH on next edge.
